// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit sitting beside the EX-stage ALU.
// Multiplies retire MUL_UNROLL bits per cycle; divides use a restoring
// algorithm at one quotient bit per cycle. Operands are converted to
// magnitudes at accept and the sign is reapplied on the final step.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 4,
  parameter bit FAST_SPEC  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_i,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd
);

  localparam int CW        = $clog2(XLEN) + 1;
  localparam int MUL_STEPS = XLEN / MUL_UNROLL;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   operand_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              special_q;
  logic [XLEN-1:0]   special_val_q;

  logic              accept;
  logic              sgn_rs1, sgn_rs2;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, is_special;
  logic [XLEN-1:0]   special_val;

  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_cand, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] mul_signed;
  logic [XLEN-1:0]   quo_signed, rem_signed;
  logic [XLEN-1:0]   final_val;

  // A request is taken only in IDLE and never in a cycle that is being flushed
  assign accept = req_valid && (state_q == S_IDLE) && !flush;

  // Decode operand signedness, form magnitudes and detect divide special cases
  always_comb begin
    sgn_rs1    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    sgn_rs2    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    neg_a      = sgn_rs1 && rs1_data[XLEN-1];
    neg_b      = sgn_rs2 && rs2_data[XLEN-1];
    mag_a      = neg_a ? -rs1_data : rs1_data;
    mag_b      = neg_b ? -rs2_data : rs2_data;
    div_zero   = (rs2_data == '0);
    div_ovf    = sgn_rs2 && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    is_special = funct3[2] && (div_zero || div_ovf);
    if (funct3[1]) begin
      special_val = div_zero ? rs1_data : '0;
    end else begin
      special_val = div_zero ? '1 : rs1_data;
    end
  end

  // Shift-add multiply: MUL_UNROLL conditional adds of the multiplicand per cycle
  always_comb begin
    mul_next = acc_q;
    mul_sum  = '0;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      mul_sum  = {1'b0, mul_next[2*XLEN-1:XLEN]} + ({1'b0, operand_q} & {(XLEN+1){mul_next[0]}});
      mul_next = {mul_sum, mul_next[XLEN-1:1]};
    end
  end

  // Restoring divide step: shift remainder left, subtract divisor if it fits
  always_comb begin
    div_cand = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_cand - {1'b0, operand_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign-correct the final step and pick the half/part the opcode asks for
  always_comb begin
    mul_signed = neg_quo_q ? -mul_next : mul_next;
    quo_signed = neg_quo_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem_signed = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    if (state_q == S_MUL) begin
      final_val = (op_q == 3'd0) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    end else if (special_q) begin
      final_val = special_val_q;
    end else begin
      final_val = op_q[1] ? rem_signed : quo_signed;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; flush always wins
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) begin
          if (FAST_SPEC && is_special) begin
            state_d = S_DONE;
          end else if (funct3[2]) begin
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) state_d = S_DONE;
      end
      S_DIV: begin
        if (cnt_q == DIV_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath: latch operands at accept, iterate, and capture the result on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      operand_q     <= '0;
      cnt_q         <= '0;
      op_q          <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      resp_data     <= '0;
      resp_rd       <= '0;
    end else if (flush) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q          <= funct3;
            cnt_q         <= '0;
            neg_quo_q     <= neg_a ^ neg_b;
            neg_rem_q     <= neg_a;
            special_q     <= is_special;
            special_val_q <= special_val;
            resp_rd       <= rd_i;
            if (funct3[2]) begin
              acc_q     <= {{XLEN{1'b0}}, mag_a};
              operand_q <= mag_b;
            end else begin
              acc_q     <= {{XLEN{1'b0}}, mag_b};
              operand_q <= mag_a;
            end
            if (FAST_SPEC && is_special) resp_data <= special_val;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          if (cnt_q == MUL_LAST) begin
            resp_data <= final_val;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DIV: begin
          acc_q <= div_next;
          if (cnt_q == DIV_LAST) begin
            resp_data <= final_val;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32, MUL_UNROLL=4, FAST_SPEC=1).
// Directed cases plus randomized operations compared against an arithmetic model.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_i;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;

  int checks = 0;
  int errors = 0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(XLEN), .MUL_UNROLL(4), .FAST_SPEC(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_i       (rd_i),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // RISC-V M-extension result computed with plain wide arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int          sa, sb;
    sa = a;
    sb = b;
    ea = {32'h0, a};
    eb = {32'h0, b};
    if (f == 3'd1 || f == 3'd2) ea = {{32{a[31]}}, a};
    if (f == 3'd1) eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int expectedLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return XLEN / 4 + 1;
    if (b == 32'h0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, measure latency, check result, hold it in DONE, then release
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int hold);
    logic [31:0] expData;
    int          expLat;
    int          edgeNum;
    expData = refModel(f, a, b);
    expLat  = expectedLatency(f, a, b);
    @(negedge clk);
    req_valid  = 1'b1;
    funct3     = f;
    rs1_data   = a;
    rs2_data   = b;
    rd_i       = rd;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    rd_i      = 5'($urandom);
    edgeNum   = 1;
    while (!resp_valid && edgeNum < 100) begin
      @(posedge clk);
      #1;
      edgeNum++;
    end
    checkOutput($sformatf("latency f%0d", f), 64'(edgeNum), 64'(expLat));
    checkOutput($sformatf("data f%0d %h %h", f, a, b), 64'(resp_data), 64'(expData));
    checkOutput("resp_rd", 64'(resp_rd), 64'(rd));
    req_valid = 1'b1;
    funct3    = 3'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 64'(resp_valid), 64'(1));
      checkOutput("hold_data", 64'(resp_data), 64'(expData));
      checkOutput("hold_rd", 64'(resp_rd), 64'(rd));
      checkOutput("done_no_ready", 64'(req_ready), 64'(0));
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_busy", 64'(busy), 64'(0));
    checkOutput("release_valid", 64'(resp_valid), 64'(0));
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    int sawValid;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    funct3     = 3'd0;
    rs1_data   = '0;
    rs2_data   = '0;
    rd_i       = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    #12;
    checkOutput("reset_req_ready", 64'(req_ready), 64'(1));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("reset_resp_data", 64'(resp_data), 64'(0));
    checkOutput("reset_resp_rd", 64'(resp_rd), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 0);
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, 5'd4, 1);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 0);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, 0);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 5'd8, 3);
    applyStimulus(3'd5, 32'd5, 32'd0, 5'd9, 0);
    applyStimulus(3'd7, 32'd5, 32'd0, 5'd10, 0);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 0);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd0, 5'd13, 0);

    // Flush during a divide
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = 3'd4;
    rs1_data  = 32'd100;
    rs2_data  = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_busy", 64'(busy), 64'(0));
    checkOutput("flush_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    flush    = 1'b0;
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) sawValid = 1;
    end
    checkOutput("flush_no_resp", 64'(sawValid), 64'(0));

    // Flush blocks an IDLE accept
    @(negedge clk);
    req_valid = 1'b1;
    flush     = 1'b1;
    funct3    = 3'd0;
    @(posedge clk);
    #1;
    checkOutput("flush_idle_busy", 64'(busy), 64'(0));
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;

    // Flush in DONE overrides a concurrent resp_ready
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = 3'd5;
    rs1_data  = 32'd5;
    rs2_data  = 32'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("fast_valid", 64'(resp_valid), 64'(1));
    checkOutput("fast_data", 64'(resp_data), 64'hFFFFFFFF);
    @(negedge clk);
    flush      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_done_valid", 64'(resp_valid), 64'(0));
    checkOutput("flush_done_busy", 64'(busy), 64'(0));
    @(negedge clk);
    flush      = 1'b0;
    resp_ready = 1'b0;

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = 3'd4;
    rs1_data  = 32'd1000;
    rs2_data  = 32'd3;
    rd_i      = 5'd17;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", 64'(busy), 64'(0));
    checkOutput("async_req_ready", 64'(req_ready), 64'(1));
    checkOutput("async_resp_rd", 64'(resp_rd), 64'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) sawValid = 1;
    end
    checkOutput("async_no_resp", 64'(sawValid), 64'(0));

    // Randomized operations
    for (int n = 0; n < 150; n++) begin
      applyStimulus(3'($urandom), pickOperand(), pickOperand(), 5'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
